entrada_handshake: RTL and testbench
====================================

Name: entrada_handshake

Overview:
- Responder side of the processor's IN-instruction protocol: the peripheral that supplies the 4-bit input word and the `check` handshake consumed by the processor top.
- Synchronizes and debounces the confirm push-button and the data switches.
- When the processor requests input (`in_req`) and the user confirms, it presents the latched switch word on `entrada` and pulses `check` so the stalled PC advances.
- Sits between the board switches/KEY and the processor's `entrada`/`check` inputs.

Parameters:
- DATA_W, 4, width of the switch word and of `entrada`.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced button level changes; legal range 2..65535.
- CNT_W, 8, width of the transfer counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_req  input  1  IN request from the control unit; high while an IN instruction is in execution.
- botao  input  1  raw confirm button, active-low (pressed = 0), asynchronous to clock.
- chaves  input  DATA_W  raw switches, asynchronous to clock.
- entrada  output  DATA_W  latched input word delivered to the register bank.
- check  output  1  data-valid handshake to the processor; high for exactly one cycle per transfer.
- aguardando  output  1  waiting-for-user indicator (LED); high in ESPERA.
- contador_in  output  CNT_W  number of completed transfers.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; entrada=0; check=0; aguardando=0; contador_in=0.
  - Synchronizer flops are set to released (1) for `botao` and to 0 for `chaves`.
  - Debounce counter=0; debounced button=released.
- Synchronization: `botao` and `chaves` each pass through 2 flops. Every later use, including the latched data, uses the synchronized values.
- Debounce:
  - When the synchronized button differs from the debounced level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - `press` is a one-cycle pulse on a debounced released→pressed transition.
  - Raw-to-`press` latency = 2 + DEBOUNCE_CYCLES cycles.
- FSM states and transitions:
  - IDLE: check=0, aguardando=0. If in_req=1 → ESPERA. A `press` in IDLE is ignored; no latch, no count.
  - ESPERA: aguardando=1.
    - in_req=0 (request withdrawn) → IDLE, with no transfer.
    - Otherwise, `press` → latch synchronized `chaves` into `entrada` and go to ENTREGUE.
  - ENTREGUE: check=1 for this single cycle; contador_in increments (wraps from 2^CNT_W-1 to 0); unconditional → LIBERA.
  - LIBERA: check=0, aguardando=0. Wait for the debounced level to return to released, then → IDLE.
    - A back-to-back IN request stalls here until the button is released, then needs a fresh press. One press equals exactly one transfer.
- Outputs are registered. `entrada` is stable from the ENTREGUE cycle until the next latch, so it is valid in the cycle `check` is high.
- Button held through reset: after reset the debounced level starts released, so a held button produces one `press` after DEBOUNCE_CYCLES+2 cycles. If in_req=1 at that point, that press is accepted.
- `press` and in_req falling in the same ESPERA cycle: the withdrawal wins → IDLE, no latch.
- Reset mid-transfer, in any state: immediate return to reset values. A `check` pulse in progress is cut.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, ESPERA=2'd1, ENTREGUE=2'd2, LIBERA=2'd3;
  - the released level constant (1'b1) for active-low keys.
- One natural sub-module, `debounce_botao`: 2-flop synchronizer, counter, and `press` pulse, parameterized by DEBOUNCE_CYCLES. The same sub-module is reusable for the reset/step keys.

Test Plan (DEBOUNCE_CYCLES=4 for the bench):
- Reset, then in_req=1, chaves=4'hA, clean press held 20 cycles → aguardando=1 until the transfer; check high exactly one cycle, 6 cycles after press; entrada=4'hA; contador_in=1; then state LIBERA until release.
- Bouncing press (toggle every cycle for 3 cycles, then stable low) with in_req=1, chaves=4'h5 → exactly one check pulse; entrada=4'h5; no pulse during the bounce.
- Press while in_req=0 → no check; entrada unchanged (0); contador_in=0. A later in_req=1 waits in ESPERA until a new press.
- Two consecutive IN requests, button held across both → one transfer only. Second check only after release plus a new press; contador_in=2; second word latched correctly (3 → C).
- in_req withdrawn in ESPERA in the same cycle as `press` → no check, state IDLE. Also: reset asserted during ENTREGUE → check=0 asynchronously and all outputs at reset values.
- contador_in preset by 255 transfers, then one more → wraps to 0.

Source files
------------

// File: rtl/entrada_handshake_pkg.sv
// entrada_handshake_pkg: shared FSM encoding and key polarity for the IN-instruction responder.
package entrada_handshake_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ESPERA   = 2'd1,
    ENTREGUE = 2'd2,
    LIBERA   = 2'd3
  } state_t;
  localparam logic RELEASED = 1'b1;
endpackage

// File: rtl/entrada_handshake_debounce.sv
// debounce_botao: 2-flop synchronizer plus stability counter for an active-low key; press pulses on a debounced release-to-press edge.
module debounce_botao
  import entrada_handshake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic nivel,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nivel_q, nivel_d;
  logic          differ, done;
  always_comb begin
    differ  = sync_q[1] != nivel_q;
    done    = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    sync_d  = {sync_q[0], botao};
    cnt_d   = (differ && !done) ? cnt_q + 1'b1 : '0;
    nivel_d = done ? ~nivel_q : nivel_q;
    press   = done && nivel_q == RELEASED;
    nivel   = nivel_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync_q  <= {2{RELEASED}};
      cnt_q   <= '0;
      nivel_q <= RELEASED;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
    end
endmodule

// File: rtl/entrada_handshake.sv
// entrada_handshake: responder for the processor IN instruction; latches the switch word on a confirmed press and pulses check once.
module entrada_handshake
  import entrada_handshake_pkg::*;
#(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic              botao,
  input  logic [DATA_W-1:0] chaves,
  output logic [DATA_W-1:0] entrada,
  output logic              check,
  output logic              aguardando,
  output logic [CNT_W-1:0]  contador_in
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] chaves_s1_q, chaves_s2_q;
  logic [DATA_W-1:0] entrada_q, entrada_d;
  logic [CNT_W-1:0]  contador_q, contador_d;
  logic              nivel, press;
  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock(clock),
    .reset(reset),
    .botao(botao),
    .nivel(nivel),
    .press(press)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      chaves_s1_q <= '0;
      chaves_s2_q <= '0;
      entrada_q   <= '0;
      contador_q  <= '0;
    end else begin
      state_q     <= state_d;
      chaves_s1_q <= chaves;
      chaves_s2_q <= chaves_s1_q;
      entrada_q   <= entrada_d;
      contador_q  <= contador_d;
    end
  // Withdrawal of in_req takes priority over a coincident press.
  always_comb begin
    state_d    = state_q;
    entrada_d  = entrada_q;
    contador_d = contador_q;
    unique case (state_q)
      IDLE:     state_d = in_req ? ESPERA : IDLE;
      ESPERA:
        if (!in_req) state_d = IDLE;
        else if (press) begin
          state_d    = ENTREGUE;
          entrada_d  = chaves_s2_q;
          contador_d = contador_q + 1'b1;
        end
      ENTREGUE: state_d = LIBERA;
      LIBERA:   state_d = nivel == RELEASED ? IDLE : LIBERA;
    endcase
  end
  always_comb begin
    check       = state_q == ENTREGUE;
    aguardando  = state_q == ESPERA;
    entrada     = entrada_q;
    contador_in = contador_q;
  end
endmodule

// File: tb/tb_entrada_handshake.sv
// tb_entrada_handshake: randomized and directed stimulus against a behavioural model of the IN handshake responder.
module tb_entrada_handshake;
  localparam int D = 4;
  localparam int M_IDLE = 0, M_WAIT = 1, M_GIVE = 2, M_HOLD = 3;
  logic       clock = 0, reset = 0, in_req = 0, botao = 1;
  logic [3:0] chaves = 0, entrada;
  logic       check, aguardando;
  logic [7:0] contador_in;
  int vectors = 0, miss = 0, pulses = 0;
  entrada_handshake #(.DATA_W(4), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .botao(botao), .chaves(chaves),
    .entrada(entrada), .check(check), .aguardando(aguardando), .contador_in(contador_in)
  );
  always #5 clock = ~clock;
  // Model: the button is seen two edges late; its clean level flips after D consecutive edges of disagreement.
  logic [1:0] m_b;
  logic [3:0] m_c0, m_c1, m_ent;
  logic       m_lvl, m_press;
  int         m_run, m_st;
  logic [7:0] m_cnt;
  assign m_press = (m_b[1] != m_lvl) && (m_run + 1 == D) && m_lvl;
  always @(posedge clock or negedge reset)
    if (!reset) begin
      m_b <= 2'b11; m_c0 <= 0; m_c1 <= 0; m_lvl <= 1; m_run <= 0;
      m_st <= M_IDLE; m_ent <= 0; m_cnt <= 0;
    end else begin
      m_b <= {m_b[0], botao};
      m_c0 <= chaves;
      m_c1 <= m_c0;
      if (m_b[1] != m_lvl && m_run + 1 == D) begin
        m_lvl <= ~m_lvl; m_run <= 0;
      end else m_run <= (m_b[1] != m_lvl) ? m_run + 1 : 0;
      case (m_st)
        M_IDLE: if (in_req) m_st <= M_WAIT;
        M_WAIT:
          if (!in_req) m_st <= M_IDLE;
          else if (m_press) begin m_st <= M_GIVE; m_ent <= m_c1; m_cnt <= m_cnt + 1; end
        M_GIVE: m_st <= M_HOLD;
        default: if (m_lvl) m_st <= M_IDLE;
      endcase
    end
  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clock)
    if (reset) begin
      cmp("check", check, m_st == M_GIVE);
      cmp("aguardando", aguardando, m_st == M_WAIT);
      cmp("entrada", entrada, m_ent);
      cmp("contador_in", contador_in, m_cnt);
      if (check) pulses++;
    end
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clock); #1; end
  endtask
  task automatic wait_check(input string nm, output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (check) begin n = i; break; end
    end
    cmp(nm, n != 0, 1);
  endtask
  task automatic do_reset();
    reset = 0; tick(2); reset = 1; tick();
  endtask
  int n, p0;
  initial begin
    tick(2);
    reset = 1;
    cmp("reset_entrada", entrada, 0);
    cmp("reset_check", check, 0);
    cmp("reset_cnt", contador_in, 0);
    // Clean press: check appears 2+D edges after the raw press.
    in_req = 1; tick();
    chaves = 4'hA; botao = 0;
    wait_check("clean_timeout", n);
    cmp("clean_latency", n, 2 + D);
    cmp("clean_entrada", entrada, 4'hA);
    cmp("clean_cnt", contador_in, 1);
    tick();
    cmp("clean_one_cycle", check, 0);
    tick(18);
    cmp("clean_hold_no_wait", aguardando, 0);
    botao = 1; tick(12);
    // Bouncing press yields a single transfer.
    p0 = pulses; chaves = 4'h5;
    botao = 0; tick(); botao = 1; tick(); botao = 0; tick();
    tick(20);
    cmp("bounce_pulses", pulses - p0, 1);
    cmp("bounce_entrada", entrada, 4'h5);
    botao = 1; tick(12);
    // Press with no request is ignored.
    in_req = 0; do_reset();
    p0 = pulses; botao = 0; tick(12);
    cmp("idle_press_pulses", pulses - p0, 0);
    cmp("idle_press_entrada", entrada, 0);
    cmp("idle_press_cnt", contador_in, 0);
    botao = 1; tick(10);
    in_req = 1; tick(15);
    cmp("espera_waits", aguardando, 1);
    cmp("espera_no_pulse", pulses - p0, 0);
    // Button held across two requests: second needs release and a new press.
    chaves = 4'h3; botao = 0;
    wait_check("b2b_first_timeout", n);
    cmp("b2b_first_entrada", entrada, 4'h3);
    tick(); in_req = 0; tick(); in_req = 1; chaves = 4'hC; p0 = pulses;
    tick(20);
    cmp("b2b_stall_pulses", pulses - p0, 0);
    cmp("b2b_stall_wait", aguardando, 0);
    botao = 1; tick(12);
    cmp("b2b_ready", aguardando, 1);
    botao = 0;
    wait_check("b2b_second_timeout", n);
    cmp("b2b_second_entrada", entrada, 4'hC);
    cmp("b2b_cnt", contador_in, 2);
    botao = 1; tick(12);
    // Withdrawal in the same cycle the press lands.
    p0 = pulses; botao = 0; tick(D + 1); in_req = 0; tick();
    cmp("withdraw_state", aguardando, 0);
    tick(3);
    cmp("withdraw_pulses", pulses - p0, 0);
    cmp("withdraw_entrada", entrada, 4'hC);
    botao = 1; tick(12);
    // Reset asserted while check is high.
    in_req = 1; tick(2); botao = 0;
    wait_check("rst_mid_timeout", n);
    reset = 0; #1;
    cmp("rst_mid_check", check, 0);
    cmp("rst_mid_entrada", entrada, 0);
    cmp("rst_mid_cnt", contador_in, 0);
    cmp("rst_mid_wait", aguardando, 0);
    tick(); botao = 1; reset = 1; tick(10);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) in_req = ~in_req;
      if ($urandom_range(9) == 0) botao = ~botao;
      chaves = 4'($urandom);
      tick();
    end
    // Counter wrap after 256 transfers.
    botao = 1; in_req = 1; tick(12); do_reset();
    for (int k = 1; k <= 256; k++) begin
      chaves = 4'($urandom); botao = 0;
      wait_check("wrap_timeout", n);
      if (k == 255) cmp("wrap_255", contador_in, 255);
      if (k == 256) cmp("wrap_0", contador_in, 0);
      tick(); botao = 1; tick(10);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
